eu_txbuf: RTL
=============

// Module: eu_txbuf
// PURPOSE
//  Transmit-side result buffer of an execution unit. Accepts ALU results (addr, data) into a 2**NUM_IDX_BITS FIFO.
//  Drains them in order onto the interconnect TX channel with a valid/ack handshake, re-sending on ack timeout.
//  Counterpart of the EU receive buffer: this block produces the (addr, data) beats that a remote EU's receive buffer consumes.
// PARAMETERS
//  NUM_IDX_BITS  2   FIFO depth = 2**NUM_IDX_BITS entries
//  ACK_TIMEOUT   15  cycles tx_valid_o may stay high without ack before a re-send; 0 disables the timeout
// PORTS
//  clk            in   1                          clock, all logic on posedge
//  reset_n        in   1                          synchronous, active-low reset
//  in_addr_i      in   $bits(type_exec_unit_addr) ALU result address/tag
//  in_data_i      in   $bits(type_exec_unit_data) ALU result data
//  in_valid_i     in   1                          ALU push request
//  in_success_o   out  1                          push accepted this cycle (comb)
//  tx_addr_o      out  $bits(type_exec_unit_addr) head entry address
//  tx_data_o      out  $bits(type_exec_unit_data) head entry data
//  tx_valid_o     out  1                          TX beat valid
//  tx_ack_i       in   1                          interconnect accepted beat
//  fill_level_o   out  NUM_IDX_BITS+1             entries held (0..2**NUM_IDX_BITS)
//  empty_o        out  1                          fill_level_o == 0
//  full_o         out  1                          fill_level_o == 2**NUM_IDX_BITS
//  retry_cnt_o    out  8                          saturating count of timeout re-sends
// BEHAVIOUR
//  Reset: pointers, fill level, FSM (IDLE), timeout counter and retry_cnt_o cleared.
//   Outputs after reset edge: tx_valid_o=0, in_success_o=0, empty_o=1, full_o=0, fill_level_o=0, tx_addr_o/tx_data_o=0.
//   Reset mid-operation flushes all entries without sending them.
//  Storage: wr/rd pointers NUM_IDX_BITS+1 wide (MSB = wrap bit); full when indices equal and wrap bits differ.
//   Pointers wrap modulo 2**NUM_IDX_BITS.
//  Push: in_success_o = in_valid_i & ~full_o. Entry written at that clock edge.
//   A push while full is rejected, even if a pop happens in the same cycle; the ALU holds and retries.
//  tx_addr_o/tx_data_o = mem[rd_ptr]. Driven 0 when empty. Held stable while tx_valid_o=1 until ack.
//  FSM states:
//   IDLE:    tx_valid_o=0 -> SEND when ~empty_o.
//   SEND:    tx_valid_o=1. tx_ack_i=1 -> pop head, clear timer. Stay SEND if (fill - 1 + push) > 0, else -> IDLE.
//            Throughput is 1 beat/cycle. If no ack and timer == ACK_TIMEOUT-1 (ACK_TIMEOUT != 0) -> BACKOFF, retry_cnt_o++ (saturate at 255).
//   BACKOFF: tx_valid_o=0 for exactly one cycle, head not popped -> SEND, timer cleared.
//  Timer counts cycles in SEND without ack. It clears on ack, on entry to SEND, and in IDLE/BACKOFF.
//  tx_ack_i is ignored whenever tx_valid_o=0.
//  Latency: push at edge t into an empty FIFO -> fill_level_o=1 in cycle t+1 -> tx_valid_o=1 in cycle t+2.
//  Simultaneous push and ack when not full: fill level unchanged; order preserved (push appended behind head).
//  fill_level_o updates at the clock edge: +1 on push only, -1 on pop only, unchanged on both.
// TESTING
//  Reset: hold reset_n=0 two cycles -> tx_valid_o=0, empty_o=1, fill_level_o=0, retry_cnt_o=0.
//  Single beat: push addr=3 data=0xA5 at edge t -> tx_valid_o=1 with addr=3, data=0xA5 from t+2; ack at t+4 -> tx_valid_o=0 at t+5, empty_o=1.
//  Fill/order: ack held 0, push 4 entries (addr 0..3) -> full_o=1; 5th push in_success_o=0.
//   Then ack held 1 -> four beats addr 0,1,2,3 on four consecutive cycles, then IDLE.
//  Full + ack + push same cycle: in_success_o=0, fill_level_o 4->3, and the rejected data is never transmitted.
//  Timeout: ACK_TIMEOUT=15, no ack -> tx_valid_o high 15 cycles, low 1 cycle, high again with same addr/data, retry_cnt_o=1.
//  Reset mid-SEND with 3 entries queued -> next cycle tx_valid_o=0, fill_level_o=0; a later push is sent first with its own data.

Source files
------------

// File: rtl/eu_txbuf.sv
// Transmit-side result buffer: queues ALU (addr, data) results and drains them in order
// onto the TX channel with a valid/ack handshake, backing off and re-sending on ack timeout.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | nothing queued, tx_valid_o low
// ST_SEND    | head entry presented, waiting for ack or timeout
// ST_BACKOFF | one-cycle gap after a timeout, head kept for re-send
module eu_txbuf #(
  parameter int NUM_IDX_BITS = 2,
  parameter int ACK_TIMEOUT  = 15,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       in_addr_i,
  input  logic [DATA_W-1:0]       in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_success_o,
  output logic [ADDR_W-1:0]       tx_addr_o,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ack_i,
  output logic [NUM_IDX_BITS:0]   fill_level_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [7:0]              retry_cnt_o
);

  localparam int DEPTH = 2 ** NUM_IDX_BITS;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam bit TMO_EN = (ACK_TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMO_EN ? TMR_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic [NUM_IDX_BITS:0] PTR_ONE = (NUM_IDX_BITS + 1)'(1);

  typedef logic [ADDR_W-1:0] type_exec_unit_addr;
  typedef logic [DATA_W-1:0] type_exec_unit_data;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_BACKOFF = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_IDX_BITS:0]   wr_ptr_q, wr_ptr_d;
  logic [NUM_IDX_BITS:0]   rd_ptr_q, rd_ptr_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [7:0]              retry_q, retry_d;
  logic                    tx_valid_q, tx_valid_d;

  type_exec_unit_addr      mem_addr_q [DEPTH];
  type_exec_unit_data      mem_data_q [DEPTH];

  logic [NUM_IDX_BITS:0]   fill;
  logic                    empty;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    tmo_hit;
  logic [NUM_IDX_BITS-1:0] wr_idx;
  logic [NUM_IDX_BITS-1:0] rd_idx;

  assign wr_idx = wr_ptr_q[NUM_IDX_BITS-1:0];
  assign rd_idx = rd_ptr_q[NUM_IDX_BITS-1:0];
  assign fill   = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[NUM_IDX_BITS] != rd_ptr_q[NUM_IDX_BITS]);

  // A full buffer rejects pushes even when the head pops in the same cycle.
  assign push    = in_valid_i & ~full;
  assign pop     = tx_valid_q & tx_ack_i;
  assign tmo_hit = TMO_EN && (state_q == ST_SEND) && !tx_ack_i && (tmr_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Timer is a down-counter reloaded outside SEND and on ack; reaching zero in SEND is the timeout.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    case (state_q)
      ST_IDLE: begin
        tmr_d = TMR_LOAD;
        if (!empty) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ack_i) begin
          tmr_d = TMR_LOAD;
          if (!((fill > PTR_ONE) || push)) state_d = ST_IDLE;
        end else if (tmo_hit) begin
          tmr_d   = TMR_LOAD;
          state_d = ST_BACKOFF;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end else if (TMO_EN) begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_BACKOFF: begin
        tmr_d   = TMR_LOAD;
        state_d = ST_SEND;
      end
      default: begin
        tmr_d   = TMR_LOAD;
        state_d = ST_IDLE;
      end
    endcase
    tx_valid_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tmr_q      <= TMR_LOAD;
      retry_q    <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tmr_q      <= tmr_d;
      retry_q    <= retry_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Storage needs no reset: reads are gated by the pointers, which are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_idx] <= in_addr_i;
      mem_data_q[wr_idx] <= in_data_i;
    end
  end

  assign in_success_o = push;
  assign tx_valid_o   = tx_valid_q;
  assign tx_addr_o    = empty ? '0 : mem_addr_q[rd_idx];
  assign tx_data_o    = empty ? '0 : mem_data_q[rd_idx];
  assign fill_level_o = fill;
  assign empty_o      = empty;
  assign full_o       = full;
  assign retry_cnt_o  = retry_q;

endmodule
